// File: rtl/push_pop_seq.sv
// Thumb PUSH/POP sequencer: one 32-bit stack transfer per listed register, then one SP writeback.
// Optional build macro PUSH_POP_ALIGN_CHECK_EN: fault on a misaligned sp_in instead of masking sp_in[1:0].
module push_pop_seq #(
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_pop,
    input  logic [7:0]  reg_list,
    input  logic        extra,
    input  logic [31:0] sp_in,
    input  logic [31:0] rd_data,
    output logic [3:0]  reg_addr,
    output logic [31:0] w_Rd,
    output logic        ld_rd,
    output logic [31:0] w_PC,
    output logic        ld_pc,
    output logic [31:0] w_SP,
    output logic        ld_sp,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam int unsigned TW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_XFER,
        S_SPWB
    } state_e;

    state_e        state_q, state_d;
    logic          is_pop_q, is_pop_d;
    logic [8:0]    rem_q, rem_d;      // bit 8 = LR (PUSH) or PC (POP)
    logic [31:0]   sp_q, sp_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   final_sp_q, final_sp_d;
    logic [TW-1:0] wait_q, wait_d;
    logic          pc_bad_q, pc_bad_d;

    logic [3:0]    count;
    logic [3:0]    cur_idx;
    logic [31:0]   four_n;
    logic [31:0]   base;
    logic          misaligned;
    logic          timeout;

`ifdef PUSH_POP_ALIGN_CHECK_EN
    assign misaligned = (sp_q[1:0] != 2'b00);
`else
    logic sp_lsb_unused;
    assign sp_lsb_unused = ^sp_in[1:0];
    assign misaligned    = 1'b0;
`endif

    // Lowest pending register is always serviced first, so R14/R15 (bit 8) go last.
    always_comb begin
        cur_idx = 4'd0;
        count   = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (rem_q[i]) cur_idx = 4'(i);
        end
        for (int i = 0; i < 9; i++) begin
            count = count + {3'b000, rem_q[i]};
        end
    end

    assign four_n  = {26'd0, count, 2'b00};
    assign base    = is_pop_q ? sp_q : sp_q - four_n;
    assign timeout = (BUS_TIMEOUT != 0) && !mem_ready && (wait_q == TW'(BUS_TIMEOUT - 1));

    // NOTE: every output and next-state value gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        is_pop_d   = is_pop_q;
        rem_d      = rem_q;
        sp_d       = sp_q;
        addr_d     = addr_q;
        final_sp_d = final_sp_q;
        wait_d     = wait_q;
        pc_bad_d   = pc_bad_q;

        reg_addr   = 4'd0;
        w_Rd       = 32'd0;
        ld_rd      = 1'b0;
        w_PC       = 32'd0;
        ld_pc      = 1'b0;
        w_SP       = 32'd0;
        ld_sp      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        busy       = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_pop_d = is_pop;
                    rem_d    = {extra, reg_list};
`ifdef PUSH_POP_ALIGN_CHECK_EN
                    sp_d     = sp_in;
`else
                    sp_d     = {sp_in[31:2], 2'b00};
`endif
                    state_d  = S_CALC;
                end
            end

            S_CALC: begin
                busy = 1'b1;
                if (count == 4'd0 || misaligned) begin
                    fault   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d     = base;
                    final_sp_d = is_pop_q ? sp_q + four_n : base;
                    wait_d     = '0;
                    pc_bad_d   = 1'b0;
                    state_d    = S_XFER;
                end
            end

            S_XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = ~is_pop_q;
                mem_addr = addr_q;
                reg_addr = (cur_idx == 4'd8) ? (is_pop_q ? 4'd15 : 4'd14) : cur_idx;
                if (!is_pop_q) mem_wdata = rd_data;

                if (mem_ready) begin
                    if (is_pop_q) begin
                        if (cur_idx == 4'd8) begin
                            ld_pc    = 1'b1;
                            w_PC     = {mem_rdata[31:1], 1'b0};
                            pc_bad_d = ~mem_rdata[0];
                        end else begin
                            ld_rd = 1'b1;
                            w_Rd  = mem_rdata;
                        end
                    end
                    rem_d  = rem_q & (rem_q - 9'd1);
                    addr_d = addr_q + 32'd4;
                    wait_d = '0;
                    if ((rem_q & (rem_q - 9'd1)) == 9'd0) state_d = S_SPWB;
                end else if (timeout) begin
                    fault   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end

            S_SPWB: begin
                busy    = 1'b1;
                ld_sp   = 1'b1;
                w_SP    = final_sp_q;
                done    = 1'b1;
                fault   = pc_bad_q;  // loaded PC without the Thumb bit
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_pop_q   <= 1'b0;
            rem_q      <= 9'd0;
            sp_q       <= 32'd0;
            addr_q     <= 32'd0;
            final_sp_q <= 32'd0;
            wait_q     <= '0;
            pc_bad_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_pop_q   <= is_pop_d;
            rem_q      <= rem_d;
            sp_q       <= sp_d;
            addr_q     <= addr_d;
            final_sp_q <= final_sp_d;
            wait_q     <= wait_d;
            pc_bad_q   <= pc_bad_d;
        end
    end

endmodule

// File: tb/tb_push_pop_seq.sv
// Self-checking bench for push_pop_seq: the bench acts as register file and stack memory and
// predicts every transfer, strobe and completion cycle from the register list and SP alone.
module tb_push_pop_seq;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_pop = 1'b0;
    logic [7:0]  reg_list = 8'd0;
    logic        extra = 1'b0;
    logic [31:0] sp_in = 32'd0;
    logic [31:0] rd_data;
    logic [3:0]  reg_addr;
    logic [31:0] w_Rd, w_PC, w_SP;
    logic        ld_rd, ld_pc, ld_sp;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        busy, done, fault;

    logic [31:0] regs [16];
    logic [31:0] mem_model [logic [31:0]];
    int          n_checks = 0;
    int          n_pass = 0;

    push_pop_seq #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
        .extra(extra), .sp_in(sp_in), .rd_data(rd_data), .reg_addr(reg_addr),
        .w_Rd(w_Rd), .ld_rd(ld_rd), .w_PC(w_PC), .ld_pc(ld_pc), .w_SP(w_SP), .ld_sp(ld_sp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[reg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic any_output();
        return |{reg_addr, w_Rd, ld_rd, w_PC, ld_pc, w_SP, ld_sp, mem_req, mem_we,
                 mem_addr, mem_wdata, busy, done, fault};
    endfunction

    // kind: 0 = aborted in CALC, 1 = bus timeout, 2 = completes with SP writeback
    task automatic run_op(input logic pop, input logic [7:0] list, input logic ext,
                          input logic [31:0] sp, input int delay);
        int          idxs[$];
        int          n, e, k, w, kind;
        logic [31:0] spe, base, fin, a, v;
        logic        misal, bad_pc, exp_req, exp_rd, exp_pc;
        logic [6:0]  obs, exp;

        for (int i = 0; i < 8; i++) if (list[i]) idxs.push_back(i);
        if (ext) idxs.push_back(pop ? 15 : 14);
        n = idxs.size();
`ifdef PUSH_POP_ALIGN_CHECK_EN
        spe   = sp;
        misal = (sp % 4) != 0;
`else
        spe   = sp & ~32'h3;
        misal = 1'b0;
`endif
        base = pop ? spe : spe - 32'(4 * n);
        fin  = pop ? spe + 32'(4 * n) : base;
        if (pop) begin
            for (int i = 0; i < n; i++) begin
                a = base + 32'(4 * i);
                if (!mem_model.exists(a)) mem_model[a] = $urandom;
            end
        end
        bad_pc = 1'b0;
        if (pop && ext && n > 0) begin
            v      = mem_model[base + 32'(4 * (n - 1))];
            bad_pc = ~v[0];
        end
        if (n == 0 || misal) begin
            kind = 0; e = 1;
        end else if (TO != 0 && delay >= int'(TO)) begin
            kind = 1; e = 1 + int'(TO);
        end else begin
            kind = 2; e = 2 + n * (delay + 1);
        end

        @(negedge clk);
        is_pop = pop; reg_list = list; extra = ext; sp_in = sp; start = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        k = 0; w = 0;
        for (int c = 1; c <= e + 1; c++) begin
            @(negedge clk);
            start = (c == 2 && e > 2);
            if (start) begin
                is_pop = 1'($urandom); reg_list = 8'($urandom); extra = 1'($urandom); sp_in = $urandom;
            end
            mem_ready = 1'b0;
            if (mem_req && k < n) begin
                if (w == delay) mem_ready = 1'b1;
                else w++;
            end
            a = mem_addr;
            mem_rdata = mem_model.exists(a) ? mem_model[a] : 32'h0;
            #1;
            exp_req = (kind == 2) ? (c >= 2 && c < e) : (kind == 1) ? (c >= 2 && c <= e) : 1'b0;
            exp_rd  = exp_req && mem_ready && pop && k < n && idxs[k] < 8;
            exp_pc  = exp_req && mem_ready && pop && k < n && idxs[k] == 15;
            obs = {busy, mem_req, ld_sp, done, fault, ld_rd, ld_pc};
            exp = {1'(c <= e), exp_req, 1'(kind == 2 && c == e), 1'(kind == 2 && c == e),
                   1'(c == e && (kind != 2 || bad_pc)), exp_rd, exp_pc};
            check($sformatf("ctrl_c%0d", c), 32'(obs), 32'(exp));

            if (mem_req && mem_ready && k < n) begin
                a = base + 32'(4 * k);
                check($sformatf("addr_k%0d", k), mem_addr, a);
                check($sformatf("reg_addr_k%0d", k), 32'(reg_addr), 32'(idxs[k]));
                check($sformatf("we_k%0d", k), 32'(mem_we), 32'(!pop));
                if (!pop) begin
                    check($sformatf("wdata_k%0d", k), mem_wdata, regs[idxs[k]]);
                    mem_model[a] = regs[idxs[k]];
                end else begin
                    v = mem_model[a];
                    if (idxs[k] == 15) begin
                        check("w_pc", w_PC, {v[31:1], 1'b0});
                        regs[15] = {v[31:1], 1'b0};
                    end else begin
                        check($sformatf("w_rd_k%0d", k), w_Rd, v);
                        regs[idxs[k]] = v;
                    end
                end
                k++;
                w = 0;
            end else if (mem_req && k < n) begin
                check($sformatf("hold_addr_k%0d", k), mem_addr, base + 32'(4 * k));
            end
            if (kind == 2 && c == e) check("w_sp", w_SP, fin);
        end
        if (kind == 2) check("beats", 32'(k), 32'(n));
        start = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = $urandom;

        repeat (3) @(negedge clk);
        #1 check("reset_outputs_zero", 32'(any_output()), 32'd0);
        rst = 1'b0;

        // PUSH {R0,R1,R3,LR}: stores at F0..FC, SP 0x200000F0, done at cycle 6
        run_op(1'b0, 8'b0000_1011, 1'b1, 32'h2000_0100, 0);
        check("push_mem_f0", mem_model[32'h2000_00F0], regs[0]);
        check("push_mem_fc", mem_model[32'h2000_00FC], regs[14]);

        // POP {R2,PC}: good Thumb bit, then PC loaded with bit0 clear
        mem_model[32'h2000_00F8] = 32'h0000_0011;
        mem_model[32'h2000_00FC] = 32'h0000_0201;
        run_op(1'b1, 8'b0000_0100, 1'b1, 32'h2000_00F8, 0);
        check("pop_r2", regs[2], 32'h0000_0011);
        check("pop_pc", regs[15], 32'h0000_0200);
        mem_model[32'h2000_00FC] = 32'h0000_0200;
        run_op(1'b1, 8'b0000_0100, 1'b1, 32'h2000_00F8, 0);

        // Slow memory: three wait cycles per beat
        run_op(1'b0, 8'b1010_0110, 1'b0, 32'h2000_0400, 3);

        // Bus timeout, then a normal op is still accepted
        run_op(1'b0, 8'b0000_0011, 1'b0, 32'h2000_0800, 100);
        run_op(1'b1, 8'b0000_0011, 1'b0, 32'h2000_0800, 0);

        // Empty list faults in CALC
        run_op(1'b0, 8'h00, 1'b0, 32'h2000_0100, 0);

        // Misaligned SP
        run_op(1'b0, 8'b0000_0101, 1'b0, 32'h2000_0102, 0);

        // Reset asserted mid-transfer
        @(negedge clk);
        is_pop = 1'b0; reg_list = 8'h0F; extra = 1'b0; sp_in = 32'h2000_0200; start = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 check("rst_pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst_mid_zero", 32'(any_output()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check($sformatf("rst_quiet_%0d", i), 32'({ld_sp, mem_req, busy}), 32'd0);
        end

        // Randomized operations
        for (int t = 0; t < 24; t++) begin
            logic [31:0] sp_r;
            logic [7:0]  list_r;
            sp_r   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
            list_r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(1'($urandom), list_r, 1'($urandom), sp_r, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/push_pop_seq.md
Name: push_pop_seq

Overview:
Multi-register PUSH/POP sequencer sitting directly downstream of the instruction decoder and alongside the core register file. It walks a Thumb register list, reads registers through the file's Rd read port (PUSH), or writes them back through the Rd/PC write ports (POP). It issues one 32-bit stack memory transfer per register and finishes with a single Stack Pointer writeback.

Parameters:
BUS_TIMEOUT, 16, cycles XFER waits for mem_ready before aborting with fault; 0 disables the timeout

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
is_pop  input  1  1 = POP, 0 = PUSH; latched at start
reg_list  input  8  R0..R7 select bits; latched at start
extra  input  1  PUSH: include LR (R14); POP: include PC (R15); latched at start
sp_in  input  32  current SP (register file r_SP); latched at start
rd_data  input  32  register file read data for reg_addr (combinational read)
reg_addr  output  4  register index to read (PUSH) or write (POP)
w_Rd  output  32  POP write data for R0..R7
ld_rd  output  1  write strobe for w_Rd at reg_addr
w_PC  output  32  POP PC value
ld_pc  output  1  PC write strobe
w_SP  output  32  final SP value
ld_sp  output  1  SP write strobe
mem_req  output  1  transfer request, held until mem_ready
mem_we  output  1  1 = store (PUSH), 0 = load (POP)
mem_addr  output  32  word address, bits [1:0] always 0
mem_wdata  output  32  store data
mem_rdata  input  32  load data, valid when mem_ready
mem_ready  input  1  transfer complete this cycle
busy  output  1  high from CALC through SPWB inclusive
done  output  1  one-cycle pulse on successful completion
fault  output  1  one-cycle pulse on abort

Behaviour:
- Reset: state IDLE; all outputs 0, including mem_addr, w_*, and strobes. A rst asserted mid-operation drops any outstanding mem_req the next edge and performs no SP writeback.
- Count N = popcount(reg_list) + extra, range 0..9. PUSH base = sp_in - 4N. POP base = sp_in. Final SP = base (PUSH) or sp_in + 4N (POP), modulo 2^32.
- Order: ascending register index; R14/R15 last. The k-th transfer (k = 0..N-1) uses mem_addr = base + 4k, so the lowest register is at the lowest address.
- States:
  - IDLE: start=1 latches inputs, goes to CALC. start while busy is ignored.
  - CALC (1 cycle): computes N, base, and the first index. N=0 pulses fault and returns to IDLE with no writes.
  - XFER: mem_req=1, mem_addr, mem_we, reg_addr stable until mem_ready.
    - PUSH: mem_wdata = rd_data for reg_addr (R14 for extra).
    - POP on the mem_ready cycle: ld_rd=1 with w_Rd=mem_rdata for R0..R7, or ld_pc=1 with w_PC = {mem_rdata[31:1],1'b0} for PC.
    - Advance on mem_ready; after the last transfer go to SPWB.
  - SPWB (1 cycle): ld_sp=1, w_SP = final SP, done=1, then IDLE.
  - POP PC whose loaded bit0=0 (ARMv6-M interworking violation): PC is still written and ld_sp/done still occur, and fault pulses in the SPWB cycle.
- Timeout: if BUS_TIMEOUT>0 and mem_ready is low for BUS_TIMEOUT consecutive XFER cycles:
  - mem_req drops, fault pulses, state returns to IDLE.
  - No ld_sp; registers already written by POP stay written.
  - Counter resets on each mem_ready.
- Latency with mem_ready tied 1: start at edge 0, CALC cycle 1, XFER cycles 2..N+1, SPWB/done cycle N+2.
- ld_rd, ld_pc, and ld_sp are never asserted in the same cycle.

Optional Feature:
PUSH_POP_ALIGN_CHECK_EN
- Defined: CALC checks sp_in[1:0]; if nonzero, it pulses fault, makes no transfers, and returns to IDLE.
- Undefined: sp_in[1:0] is treated as 00 for all address and final-SP arithmetic, and no fault is raised.

Test Plan:
- PUSH {R0,R1,R3,LR}, sp_in=0x2000_0100, mem_ready=1 -> stores to 0x200000F0/F4/F8/FC with R0,R1,R3,R14 data; ld_sp with w_SP=0x200000F0 and done at cycle 6.
- POP {R2,PC}, sp_in=0x200000F8, memory holds 0x11 and 0x0000_0201 -> ld_rd R2=0x11, then ld_pc w_PC=0x200, then w_SP=0x20000100, done=1, fault=0; repeat with 0x200 loaded -> fault=1 in SPWB.
- PUSH with mem_ready delayed 3 cycles per beat -> mem_req/mem_addr held stable; done at cycle 2+4N+... (each beat 4 cycles) with correct SP.
- mem_ready held low 16 cycles, BUS_TIMEOUT=16 -> fault pulse, no ld_sp, busy low next cycle; start accepted afterwards.
- Empty list (reg_list=0, extra=0) -> fault at cycle 1, no mem_req; start pulsed during busy ignored; rst mid-XFER -> all outputs 0 next edge.
- With PUSH_POP_ALIGN_CHECK_EN, sp_in=0x20000102 -> fault, no transfers; without it -> addresses based on 0x20000100.
